// File: rtl/hazard_forward_unit.sv
// Purpose: operand bypass select for NUM_SRC decode operands, plus a load-use / memory-wait stall FSM and a stall-cycle counter.
// Latency: bypass selects and stall controls are combinational on the current inputs and state; the state and the counter update on each clock edge.
// Backpressure: while Mem_Busy is high the whole pipeline is frozen; a load-use hazard holds PC and IF/ID and inserts LOAD_LAT bubbles into ID/EX.
module hazard_forward_unit #(
  parameter int NUM_SRC  = 2,
  parameter int ADDR_W   = 5,
  parameter int FWD_EX   = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [NUM_SRC*ADDR_W-1:0] Src_Addr,
  input  logic [NUM_SRC-1:0]        Src_Used,
  input  logic                      RegWrite_EX,
  input  logic                      MemRead_EX,
  input  logic [ADDR_W-1:0]         WriteRegAddress_EX,
  input  logic                      RegWrite_MEM,
  input  logic [ADDR_W-1:0]         WriteRegAddress_MEM,
  input  logic                      RegWrite_WB,
  input  logic [ADDR_W-1:0]         WriteRegAddress_WB,
  input  logic                      Mem_Busy,
  input  logic                      Flush,
  input  logic                      Clear_Count,
  output logic [2*NUM_SRC-1:0]      ReadDataSel,
  output logic                      Stall_IF,
  output logic                      Stall_ID,
  output logic                      Bubble_EX,
  output logic                      Freeze,
  output logic [CNT_W-1:0]          StallCycles
);

  // Bubble counter is wide enough to hold LOAD_LAT-1.
  localparam int CW = $clog2(LOAD_LAT + 1);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;
  localparam logic [1:0] SEL_EX  = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [ADDR_W-1:0]     src_a [NUM_SRC];
  logic [2*NUM_SRC-1:0]  sel_raw;
  logic                  load_use;
  logic                  stall_raw;
  logic                  bubble_raw;
  logic                  freeze_raw;

  // Unpack operand addresses so the forwarding and hazard loops read cleanly.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_a[i] = Src_Addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Bypass select per operand, nearest producing stage first; r0 never forwards.
  // A load in EX has no data yet, so it is excluded from the EX bypass.
  always_comb begin
    sel_raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_a[i] != '0) begin
        if ((FWD_EX != 0) && RegWrite_EX && !MemRead_EX &&
            (WriteRegAddress_EX == src_a[i])) begin
          sel_raw[2*i +: 2] = SEL_EX;
        end else if (RegWrite_MEM && (WriteRegAddress_MEM == src_a[i])) begin
          sel_raw[2*i +: 2] = SEL_MEM;
        end else if (RegWrite_WB && (WriteRegAddress_WB == src_a[i])) begin
          sel_raw[2*i +: 2] = SEL_WB;
        end else begin
          sel_raw[2*i +: 2] = SEL_RF;
        end
      end
    end
  end

  // Load-use hazard: a used operand needs the result of the load now in EX.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Src_Used[i] && (src_a[i] != '0) && RegWrite_EX && MemRead_EX &&
          (WriteRegAddress_EX == src_a[i])) begin
        load_use = 1'b1;
      end
    end
  end

  // Stall FSM next state and raw control outputs.
  // Mem_Busy outranks Flush, which outranks the load-use hazard.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    freeze_raw = 1'b0;
    case (state_q)
      RUN: begin
        if (Mem_Busy) begin
          state_d = MEM_WAIT;
          ret_d   = RUN;
        end else if (load_use && !Flush) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LU_STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
      end
      LU_STALL: begin
        if (Mem_Busy) begin
          // The dependent instruction is still parked in ID, so keep it held;
          // the remaining bubble count is frozen until memory completes.
          // A simultaneous flush kills that instruction, so resume in RUN.
          stall_raw  = !Flush;
          bubble_raw = !Flush;
          state_d    = MEM_WAIT;
          ret_d      = Flush ? RUN : LU_STALL;
        end else if (Flush) begin
          state_d = RUN;
        end else begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        freeze_raw = 1'b1;
        stall_raw  = 1'b1;
        if (Flush) begin
          ret_d = RUN;
        end
        if (!Mem_Busy) begin
          state_d = Flush ? RUN : ret_q;
        end
      end
      default: begin
        state_d = RUN;
        ret_d   = RUN;
      end
    endcase
  end

  // Outputs are held inactive for as long as reset is asserted.
  always_comb begin
    ReadDataSel = Reset_n ? sel_raw : '0;
    Stall_IF    = Reset_n & stall_raw;
    Stall_ID    = Reset_n & stall_raw;
    Bubble_EX   = Reset_n & bubble_raw;
    Freeze      = Reset_n & freeze_raw;
  end

  // Saturating count of held cycles; a clear request beats the increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Clear_Count) begin
      stall_cnt_d = '0;
    end else if ((Stall_ID || Freeze) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, return state, bubble count and stall counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: two instances share stimulus,
// u_a with LOAD_LAT=1 / 16-bit counter, u_b with LOAD_LAT=3 / 4-bit counter.
module tb_hazard_forward_unit;

  logic        Clock;
  logic        Reset_n;
  logic [9:0]  Src_Addr;
  logic [1:0]  Src_Used;
  logic        RegWrite_EX;
  logic        MemRead_EX;
  logic [4:0]  WriteRegAddress_EX;
  logic        RegWrite_MEM;
  logic [4:0]  WriteRegAddress_MEM;
  logic        RegWrite_WB;
  logic [4:0]  WriteRegAddress_WB;
  logic        Mem_Busy;
  logic        Flush;
  logic        Clear_Count;

  logic [3:0]  a_sel, b_sel;
  logic        a_stall_if, a_stall_id, a_bubble, a_freeze;
  logic        b_stall_if, b_stall_id, b_bubble, b_freeze;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int checks;
  int failures;

  hazard_forward_unit #(
    .NUM_SRC(2), .ADDR_W(5), .FWD_EX(1), .LOAD_LAT(1), .CNT_W(16)
  ) u_a (
    .Clock(Clock), .Reset_n(Reset_n), .Src_Addr(Src_Addr), .Src_Used(Src_Used),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .WriteRegAddress_EX(WriteRegAddress_EX),
    .RegWrite_MEM(RegWrite_MEM), .WriteRegAddress_MEM(WriteRegAddress_MEM),
    .RegWrite_WB(RegWrite_WB), .WriteRegAddress_WB(WriteRegAddress_WB),
    .Mem_Busy(Mem_Busy), .Flush(Flush), .Clear_Count(Clear_Count),
    .ReadDataSel(a_sel), .Stall_IF(a_stall_if), .Stall_ID(a_stall_id),
    .Bubble_EX(a_bubble), .Freeze(a_freeze), .StallCycles(a_cnt)
  );

  hazard_forward_unit #(
    .NUM_SRC(2), .ADDR_W(5), .FWD_EX(1), .LOAD_LAT(3), .CNT_W(4)
  ) u_b (
    .Clock(Clock), .Reset_n(Reset_n), .Src_Addr(Src_Addr), .Src_Used(Src_Used),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .WriteRegAddress_EX(WriteRegAddress_EX),
    .RegWrite_MEM(RegWrite_MEM), .WriteRegAddress_MEM(WriteRegAddress_MEM),
    .RegWrite_WB(RegWrite_WB), .WriteRegAddress_WB(WriteRegAddress_WB),
    .Mem_Busy(Mem_Busy), .Flush(Flush), .Clear_Count(Clear_Count),
    .ReadDataSel(b_sel), .Stall_IF(b_stall_if), .Stall_ID(b_stall_id),
    .Bubble_EX(b_bubble), .Freeze(b_freeze), .StallCycles(b_cnt)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    Src_Addr            = '0;
    Src_Used            = '0;
    RegWrite_EX         = 1'b0;
    MemRead_EX          = 1'b0;
    WriteRegAddress_EX  = '0;
    RegWrite_MEM        = 1'b0;
    WriteRegAddress_MEM = '0;
    RegWrite_WB         = 1'b0;
    WriteRegAddress_WB  = '0;
    Mem_Busy            = 1'b0;
    Flush               = 1'b0;
    Clear_Count         = 1'b0;
  endtask

  task automatic adv();
    @(posedge Clock);
    #1;
  endtask

  task automatic smp();
    @(negedge Clock);
  endtask

  // Load in EX writing r, operand 0 of the ID instruction reads r.
  task automatic load_hazard(input logic [4:0] r);
    Src_Addr[4:0]      = r;
    Src_Used[0]        = 1'b1;
    RegWrite_EX        = 1'b1;
    MemRead_EX         = 1'b1;
    WriteRegAddress_EX = r;
  endtask

  logic [7:0] busy_v, frz_v, stl_v, bub_v;

  initial begin
    checks   = 0;
    failures = 0;
    busy_v   = 8'b0000_1111;
    frz_v    = 8'b0001_1110;
    stl_v    = 8'b0111_1111;
    bub_v    = 8'b0110_0001;

    // Reset held with forwarding and hazard conditions present: all outputs low.
    Reset_n = 1'b0;
    clr_in();
    Src_Addr[4:0] = 5'd3; RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd3;
    Src_Addr[9:5] = 5'd5; Src_Used = 2'b10;
    RegWrite_EX = 1'b1; MemRead_EX = 1'b1; WriteRegAddress_EX = 5'd5;
    smp();
    chk("rst_sel", a_sel, 0);
    chk("rst_stall_id", a_stall_id, 0);
    chk("rst_bubble", a_bubble, 0);
    chk("rst_b_stall_if", b_stall_if, 0);
    chk("rst_freeze", a_freeze, 0);
    chk("rst_cnt_a", a_cnt, 0);
    chk("rst_cnt_b", b_cnt, 0);
    adv();
    Reset_n = 1'b1;
    clr_in();

    // MEM beats WB; WB used when MEM not writing; r0 never forwarded.
    adv();
    clr_in();
    Src_Addr[4:0] = 5'd3;
    RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd3;
    RegWrite_WB  = 1'b1; WriteRegAddress_WB  = 5'd3;
    smp();
    chk("t1_mem_over_wb", a_sel[1:0], 1);
    adv();
    RegWrite_MEM = 1'b0;
    smp();
    chk("t1_wb", a_sel[1:0], 2);
    adv();
    clr_in();
    RegWrite_EX = 1'b1; RegWrite_MEM = 1'b1; RegWrite_WB = 1'b1;
    smp();
    chk("t1_r0", a_sel, 0);

    // EX non-load forwarding beats MEM; a load in EX stalls one cycle then MEM forwards.
    adv();
    clr_in();
    Src_Addr[9:5] = 5'd5; Src_Used = 2'b10;
    RegWrite_EX = 1'b1; WriteRegAddress_EX = 5'd5;
    RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd5;
    smp();
    chk("t2_ex_sel", a_sel[3:2], 3);
    chk("t2_ex_nostall", a_stall_id, 0);
    adv();
    RegWrite_MEM = 1'b0; WriteRegAddress_MEM = 5'd0;
    MemRead_EX = 1'b1;
    smp();
    chk("t2_lu_stall_id", a_stall_id, 1);
    chk("t2_lu_stall_if", a_stall_if, 1);
    chk("t2_lu_bubble", a_bubble, 1);
    chk("t2_lu_sel", a_sel[3:2], 0);
    adv();
    clr_in();
    Src_Addr[9:5] = 5'd5; Src_Used = 2'b10;
    RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd5;
    smp();
    chk("t2_after_sel", a_sel[3:2], 1);
    chk("t2_after_stall", a_stall_id, 0);
    chk("t2_after_bubble", a_bubble, 0);
    chk("t2_cnt_a", a_cnt, 1);
    adv();
    clr_in();
    adv();
    Clear_Count = 1'b1;
    adv();
    Clear_Count = 1'b0;
    smp();
    chk("clr_cnt_b", b_cnt, 0);
    chk("clr_cnt_a", a_cnt, 0);
    chk("clr_b_idle", b_stall_id, 0);

    // LOAD_LAT=3: exactly three stall+bubble cycles, counter 0..3.
    adv();
    clr_in();
    load_hazard(5'd7);
    smp();
    chk("t3_c0_stall", b_stall_id, 1);
    chk("t3_c0_bubble", b_bubble, 1);
    chk("t3_c0_freeze", b_freeze, 0);
    chk("t3_c0_cnt", b_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      adv();
      clr_in();
      Src_Addr[4:0] = 5'd7; Src_Used = 2'b01;
      RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd7;
      smp();
      chk("t3_stall", b_stall_id, (k < 3) ? 1 : 0);
      chk("t3_bubble", b_bubble, (k < 3) ? 1 : 0);
      chk("t3_cnt", b_cnt, k);
    end
    chk("t3_cnt_a", a_cnt, 1);

    // Mem_Busy during the first LU_STALL cycle: four freeze cycles, then two stalls.
    adv();
    clr_in();
    load_hazard(5'd7);
    smp();
    chk("t4_u0_stall", b_stall_id, 1);
    chk("t4_u0_cnt", b_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      adv();
      clr_in();
      Mem_Busy = busy_v[i];
      smp();
      chk("t4_freeze", b_freeze, frz_v[i]);
      chk("t4_stall_id", b_stall_id, stl_v[i]);
      chk("t4_stall_if", b_stall_if, stl_v[i]);
      chk("t4_bubble", b_bubble, bub_v[i]);
      if (i == 1) chk("t4_cnt_pre", b_cnt, 5);
      if (i == 7) chk("t4_cnt_post", b_cnt, 11);
    end

    // Flush in the first LU_STALL cycle cancels the remaining bubbles.
    adv();
    clr_in();
    load_hazard(5'd7);
    smp();
    chk("t5_v0_stall", b_stall_id, 1);
    adv();
    clr_in();
    Flush = 1'b1;
    smp();
    chk("t5_flush_stall", b_stall_id, 0);
    chk("t5_flush_bubble", b_bubble, 0);
    chk("t5_flush_stall_if", b_stall_if, 0);
    adv();
    clr_in();
    smp();
    chk("t5_run_stall", b_stall_id, 0);
    // Unused operand: no stall, but select codes still reflect matches.
    adv();
    clr_in();
    load_hazard(5'd7);
    Src_Used = 2'b00;
    RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd7;
    smp();
    chk("t5_unused_b", b_stall_id, 0);
    chk("t5_unused_a", a_stall_id, 0);
    chk("t5_unused_bubble", b_bubble, 0);
    chk("t5_unused_sel", a_sel[1:0], 1);
    // Flush alongside a hazard in RUN suppresses the stall.
    adv();
    clr_in();
    load_hazard(5'd7);
    Flush = 1'b1;
    smp();
    chk("t5_flush_hz_b", b_stall_id, 0);
    chk("t5_flush_hz_a", a_stall_id, 0);
    adv();
    clr_in();
    smp();
    chk("t5_flush_hz_next", b_stall_id, 0);

    // Saturation: 14 freeze cycles bring the 4-bit counter to max-1.
    adv();
    clr_in();
    Clear_Count = 1'b1;
    adv();
    clr_in();
    Mem_Busy = 1'b1;
    smp();
    chk("t6_cleared", b_cnt, 0);
    for (int i = 1; i < 14; i++) adv();
    adv();
    clr_in();
    adv();
    clr_in();
    load_hazard(5'd7);
    smp();
    chk("t6_max_m1", b_cnt, 14);
    chk("t6_stall0", b_stall_id, 1);
    adv();
    clr_in();
    smp();
    chk("t6_sat1", b_cnt, 15);
    chk("t6_stall1", b_stall_id, 1);
    adv();
    smp();
    chk("t6_sat2", b_cnt, 15);
    adv();
    smp();
    chk("t6_sat3", b_cnt, 15);
    chk("t6_idle", b_stall_id, 0);
    Clear_Count = 1'b1;
    adv();
    Clear_Count = 1'b0;
    smp();
    chk("t6_clear", b_cnt, 0);

    // Reset asserted mid-LU_STALL drops every output at once.
    adv();
    clr_in();
    load_hazard(5'd7);
    Src_Addr[9:5] = 5'd3;
    RegWrite_MEM = 1'b1; WriteRegAddress_MEM = 5'd3;
    smp();
    chk("t7_x0_stall", b_stall_id, 1);
    adv();
    chk("t7_lu_stall", b_stall_id, 1);
    chk("t7_lu_sel", a_sel[3:2], 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t7_rst_stall_id", b_stall_id, 0);
    chk("t7_rst_stall_if", b_stall_if, 0);
    chk("t7_rst_bubble", b_bubble, 0);
    chk("t7_rst_freeze", b_freeze, 0);
    chk("t7_rst_sel_a", a_sel, 0);
    chk("t7_rst_sel_b", b_sel, 0);
    chk("t7_rst_cnt", b_cnt, 0);
    adv();
    Reset_n = 1'b1;
    clr_in();
    smp();
    chk("t7_after_rst", b_stall_id, 0);
    chk("t7_after_bubble", b_bubble, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
